rob_commit: RTL
===============

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter SIZE, default 8, ROB entry count (power of two).
REQ-002 SHALL have parameter COMMIT_W, default 4, max entries retired per cycle.
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enq_valid  in  1  dispatch offers one instruction.
REQ-006 SHALL have port enq_pci  in  pci_t  decoded instruction info (pc, opcode, rd, funct3, imms).
REQ-007 SHALL have port enq_ready  out  1  entry available.
REQ-008 SHALL have port enq_tag  out  $clog2(SIZE)  tag assigned to the offered instruction (tail).
REQ-009 SHALL have ports wb_valid in 1, wb_tag in $clog2(SIZE), wb_data in 32, wb_mispredict in 1, wb_target in 32: execution result for one entry.
REQ-010 SHALL have port commit  out  1  at least one entry retires this cycle.
REQ-011 SHALL have port num_deq  out  $clog2(SIZE)+1  entries retired this cycle.
REQ-012 SHALL have port front_tag  out  $clog2(SIZE)  head tag (oldest entry).
REQ-013 SHALL have port rdest  out  sal2_t[SIZE]  per-entry view: rdy, data, pc_info.
REQ-014 SHALL have ports rf_we out COMMIT_W, rf_rd out 5 x COMMIT_W, rf_data out 32 x COMMIT_W: regfile write slots, slot i = entry (head+i)%SIZE.
REQ-015 SHALL have ports flush out 1, flush_pc out 32: redirect on retired mispredict.
REQ-016 SHALL have ports full out 1, empty out 1.

Function
REQ-017 SHALL hold head, tail, count (0..SIZE) registers; full = count==SIZE, empty = count==0; pointers wrap modulo SIZE.
REQ-018 SHALL drive enq_ready = !full && !flush; on enq_valid && enq_ready, write entry at tail (valid=1, rdy=0, mispredict=0), tail+1.
REQ-019 SHALL decide enq_ready from current count; a commit in the same cycle does not admit an enqueue into a full ROB.
REQ-020 SHALL, on wb_valid to a valid, not-rdy entry, set rdy=1, data=wb_data, mispredict, target at next posedge; wb to an invalid or already-rdy entry ignored.
REQ-021 SHALL compute k = count of contiguous valid&&rdy entries from head, capped at COMMIT_W, truncated after (inclusive) the first mispredicted entry.
REQ-022 SHALL drive commit = k!=0, num_deq = k, front_tag = head, rf_* combinationally in the same cycle; head advances by k and count updates by (enq - k) at the posedge.
REQ-023 SHALL assert rf_we[i] only for i<k, rd!=0, and opcode in {op_imm, op_reg, op_lui, op_auipc, op_jal, op_jalr, op_load}; rf_data[i] = entry data.
REQ-024 SHALL, when a retired entry in the window has mispredict=1, assert flush for that cycle with flush_pc = its target; at the posedge invalidate all entries and set head=tail=count=0; enqueue and wb that cycle are dropped.
REQ-025 SHALL retire entries strictly in program order; a not-rdy head blocks all younger rdy entries.
REQ-026 SHALL drive rdest[j].rdy = valid&&rdy of entry j, data and pc_info from entry j.

Reset
REQ-027 SHALL, on rst low (async), clear head, tail, count, all valid/rdy/mispredict bits; outputs: commit=0, num_deq=0, front_tag=0, rf_we=0, flush=0, flush_pc=0, empty=1, full=0, enq_ready=1 after deassertion.
REQ-028 SHALL discard in-flight entries on reset mid-operation; no retirement in the first cycle after deassertion.

Structure
REQ-029 SHALL place rob_entry_t (valid, rdy, mispredict, data, target, pci_t) in rv32i_types; pci_t and sal2_t reused unchanged.
REQ-030 SHALL use one sub-module rob_commit_select: combinational k/mispredict-truncation scan from head over the entry array.

Verification
REQ-031 SHALL test: enqueue 3 addi (pc 0x60,0x64,0x68), wb tags 2,1,0 out of order -> single cycle commit=1, num_deq=3, front_tag=0, rf_we=3'b111.
REQ-032 SHALL test: fill 8 entries -> full=1, enq_ready=0; wb all, retire 4 then 4 -> num_deq=4 twice, empty=1.
REQ-033 SHALL test: head at tag 6, entries 6,7,0,1 rdy -> num_deq=4, rf slots map tags 6,7,0,1 (wrap).
REQ-034 SHALL test: tags 0..3 rdy, tag 1 is branch mispredict target 0x100 -> num_deq=2, flush=1, flush_pc=0x100, next cycle count=0, head=0.
REQ-035 SHALL test: head not rdy, tags 1..5 rdy -> commit=0 until head wb; rd=x0 and op_store entries retire with rf_we=0.
REQ-036 SHALL test: rst low with 5 valid entries -> next cycle empty=1, commit=0, no rf writes.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types and the reorder-buffer entry layout.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        rv32i_opcode opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } pci_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
        pci_t        pc_info;
    } sal2_t;

    typedef struct packed {
        logic        valid;
        logic        rdy;
        logic        mispredict;
        logic [31:0] data;
        logic [31:0] target;
        pci_t        pci;
    } rob_entry_t;

    function automatic logic writes_rd(rv32i_opcode op);
        return op inside {op_imm, op_reg, op_lui, op_auipc, op_jal, op_jalr, op_load};
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Retirement window scan: counts ready entries from head, stopping after the first mispredict.
module rob_commit_select
    import rv32i_types::*;
#(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned COMMIT_W = 4
) (
    input  rob_entry_t                entries [SIZE],
    input  logic [$clog2(SIZE)-1:0]   head,
    output logic [$clog2(SIZE):0]     k,
    output logic                      flush,
    output logic [31:0]               flush_pc
);
    localparam int unsigned IW = $clog2(SIZE);
    localparam int unsigned CW = IW + 1;

    logic stop;

    always_comb begin
        k        = '0;
        flush    = 1'b0;
        flush_pc = '0;
        stop     = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (!stop && entries[head + IW'(i)].valid && entries[head + IW'(i)].rdy) begin
                k = k + CW'(1);
                // A mispredicted entry retires, but nothing younger may follow it.
                if (entries[head + IW'(i)].mispredict) begin
                    flush    = 1'b1;
                    flush_pc = entries[head + IW'(i)].target;
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order multi-wide retirement with regfile write slots and mispredict flush.
module rob_commit
    import rv32i_types::*;
#(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned COMMIT_W = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enq_valid,
    input  pci_t                             enq_pci,
    output logic                             enq_ready,
    output logic [$clog2(SIZE)-1:0]          enq_tag,
    input  logic                             wb_valid,
    input  logic [$clog2(SIZE)-1:0]          wb_tag,
    input  logic [31:0]                      wb_data,
    input  logic                             wb_mispredict,
    input  logic [31:0]                      wb_target,
    output logic                             commit,
    output logic [$clog2(SIZE):0]            num_deq,
    output logic [$clog2(SIZE)-1:0]          front_tag,
    output sal2_t                            rdest [SIZE],
    output logic [COMMIT_W-1:0]              rf_we,
    output logic [COMMIT_W-1:0][4:0]         rf_rd,
    output logic [COMMIT_W-1:0][31:0]        rf_data,
    output logic                             flush,
    output logic [31:0]                      flush_pc,
    output logic                             full,
    output logic                             empty
);
    localparam int unsigned IW = $clog2(SIZE);
    localparam int unsigned CW = IW + 1;

    rob_entry_t      entries_q [SIZE];
    rob_entry_t      entries_d [SIZE];
    logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            enq_fire;

    rob_commit_select #(
        .SIZE     (SIZE),
        .COMMIT_W (COMMIT_W)
    ) u_select (
        .entries  (entries_q),
        .head     (head_q),
        .k        (num_deq),
        .flush    (flush),
        .flush_pc (flush_pc)
    );

    assign full      = count_q == CW'(SIZE);
    assign empty     = count_q == '0;
    assign enq_ready = !full && !flush;
    assign enq_fire  = enq_valid && enq_ready;
    assign enq_tag   = tail_q;
    assign front_tag = head_q;
    assign commit    = num_deq != '0;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            rf_we[i]   = (CW'(i) < num_deq) && (entries_q[head_q + IW'(i)].pci.rd != 5'd0)
                         && writes_rd(entries_q[head_q + IW'(i)].pci.opcode);
            rf_rd[i]   = entries_q[head_q + IW'(i)].pci.rd;
            rf_data[i] = entries_q[head_q + IW'(i)].data;
        end
    end

    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            rdest[j].rdy     = entries_q[j].valid && entries_q[j].rdy;
            rdest[j].data    = entries_q[j].data;
            rdest[j].pc_info = entries_q[j].pci;
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            for (int j = 0; j < SIZE; j++) begin
                entries_d[j].valid      = 1'b0;
                entries_d[j].rdy        = 1'b0;
                entries_d[j].mispredict = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_valid && entries_q[wb_tag].valid && !entries_q[wb_tag].rdy) begin
                entries_d[wb_tag].rdy        = 1'b1;
                entries_d[wb_tag].data       = wb_data;
                entries_d[wb_tag].mispredict = wb_mispredict;
                entries_d[wb_tag].target     = wb_target;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (CW'(i) < num_deq) begin
                    entries_d[head_q + IW'(i)].valid = 1'b0;
                    entries_d[head_q + IW'(i)].rdy   = 1'b0;
                end
            end
            // The tail slot is never in the retiring window unless full, which blocks enqueue.
            if (enq_fire) begin
                entries_d[tail_q].valid      = 1'b1;
                entries_d[tail_q].rdy        = 1'b0;
                entries_d[tail_q].mispredict = 1'b0;
                entries_d[tail_q].pci        = enq_pci;
                tail_d                       = tail_q + IW'(1);
            end
            head_d  = head_q + IW'(num_deq);
            count_d = count_q + CW'(enq_fire) - num_deq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int j = 0; j < SIZE; j++) begin
                entries_q[j] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule
